ldpc_cn_minsearch_ctrl: RTL and testbench

- Sequences the check-node min-search for the non-binary LDPC decoder kernel.
- Accepts a stream of dc packed SIMD operand words, one beat per handshake, and keeps per-lane min1, min2 and the beat index of min1.
- Lane compare uses the same signed Q-bit ordering as the LDN_MIN / LDN_IDXCOMPV3 ALU ops.
- Sits between the operand buffer / load path and the check-node update stage, replacing a software loop of LDN_MIN + LDN_IDXCOMPV3 instructions.

---
 rtl/ldpc_cn_minsearch_ctrl.sv | 156 +++++++++++++++
 tb/tb_ldpc_cn_minsearch_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_cn_minsearch_ctrl.sv
// Check-node min-search sequencer: streams dc SIMD operand beats and tracks
// per-lane min1, min2 and the beat index of min1 using signed Q-bit ordering.
module ldpc_cn_minsearch_ctrl #(
    parameter int unsigned Q      = 8,
    parameter int unsigned SIMD   = 4,
    parameter int unsigned DC_MAX = 16,
    parameter int unsigned IDXW   = $clog2(DC_MAX)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   start_i,
    input  logic [IDXW:0]          dc_i,
    output logic                   busy_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [Q*SIMD-1:0]      in_data_i,
    output logic                   done_o,
    output logic [Q*SIMD-1:0]      min1_o,
    output logic [Q*SIMD-1:0]      min2_o,
    output logic [IDXW*SIMD-1:0]   idx_o
);

    localparam int unsigned DW = Q * SIMD;
    localparam int unsigned IW = IDXW * SIMD;
    localparam logic [Q-1:0] LANE_MAX = {1'b0, {(Q-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDXW-1:0] cnt_q;
    logic [IDXW-1:0] dc_last_q, dc_last_d;
    logic [IDXW:0]   dc_clamped;
    logic [DW-1:0]   acc_min1_q, acc_min2_q, acc_min1_d, acc_min2_d;
    logic [IW-1:0]   acc_idx_q, acc_idx_d;
    logic            accept, last_beat, init;

    // Degree is clamped to [2, DC_MAX]; the last beat index is what the run compares against.
    always_comb begin
        dc_clamped = dc_i;
        if (dc_i < (IDXW+1)'(2)) begin
            dc_clamped = (IDXW+1)'(2);
        end else if (dc_i > (IDXW+1)'(DC_MAX)) begin
            dc_clamped = (IDXW+1)'(DC_MAX);
        end
        dc_last_d = IDXW'(dc_clamped - (IDXW+1)'(1));
    end

    // Per-lane compare/insert; ties fall through to min2 so the first occurrence keeps idx.
    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        logic signed [Q-1:0] v, m1, m2, nm1, nm2;
        logic [IDXW-1:0]     nidx;

        assign v  = in_data_i[i*Q +: Q];
        assign m1 = acc_min1_q[i*Q +: Q];
        assign m2 = acc_min2_q[i*Q +: Q];

        always_comb begin
            nm1  = m1;
            nm2  = m2;
            nidx = acc_idx_q[i*IDXW +: IDXW];
            if (v < m1) begin
                nm2  = m1;
                nm1  = v;
                nidx = cnt_q;
            end else if (v < m2) begin
                nm2 = v;
            end
        end

        assign acc_min1_d[i*Q +: Q]       = nm1;
        assign acc_min2_d[i*Q +: Q]       = nm2;
        assign acc_idx_d[i*IDXW +: IDXW]  = nidx;
    end

    // Next-state logic; flush overrides everything and discards a same-cycle beat.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_beat = 1'b0;
        init      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    init    = 1'b1;
                end
            end
            S_RUN: begin
                accept = in_valid_i;
                if (in_valid_i && (cnt_q == dc_last_q)) begin
                    state_d   = S_DONE;
                    last_beat = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d   = S_IDLE;
            accept    = 1'b0;
            last_beat = 1'b0;
            init      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            busy_o     <= 1'b0;
            in_ready_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_o     <= (state_d != S_IDLE);
            in_ready_o <= (state_d == S_RUN);
            done_o     <= (state_d == S_DONE);
        end
    end

    // Accumulators restart on start; visible outputs only change on the final beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_min1_q <= '0;
            acc_min2_q <= '0;
            acc_idx_q  <= '0;
            cnt_q      <= '0;
            dc_last_q  <= '0;
            min1_o     <= '0;
            min2_o     <= '0;
            idx_o      <= '0;
        end else if (init) begin
            acc_min1_q <= {SIMD{LANE_MAX}};
            acc_min2_q <= {SIMD{LANE_MAX}};
            acc_idx_q  <= '0;
            cnt_q      <= '0;
            dc_last_q  <= dc_last_d;
        end else if (accept) begin
            acc_min1_q <= acc_min1_d;
            acc_min2_q <= acc_min2_d;
            acc_idx_q  <= acc_idx_d;
            cnt_q      <= last_beat ? '0 : cnt_q + IDXW'(1);
            if (last_beat) begin
                min1_o <= acc_min1_d;
                min2_o <= acc_min2_d;
                idx_o  <= acc_idx_d;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_cn_minsearch_ctrl.sv
// Scoreboard bench for ldpc_cn_minsearch_ctrl: a sort-style reference model
// predicts results at start; a monitor pops and compares on every done_o.
module tb_ldpc_cn_minsearch_ctrl;

    localparam int SIMD = 4;
    localparam int IDXW = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, start_i, in_valid_i;
    logic [4:0]  dc_i;
    logic [31:0] in_data_i;
    logic        busy_o, in_ready_o, done_o;
    logic [31:0] min1_o, min2_o;
    logic [15:0] idx_o;

    typedef struct packed {
        logic [31:0] m1;
        logic [31:0] m2;
        logic [15:0] idx;
    } exp_t;

    exp_t        sb[$];
    exp_t        prev;
    exp_t        mon_e;
    logic [31:0] bq[$];
    logic [31:0] tmp;
    int          n_cmp = 0;
    int          n_fail = 0;

    ldpc_cn_minsearch_ctrl #(.Q(8), .SIMD(4), .DC_MAX(16), .IDXW(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .start_i    (start_i),
        .dc_i       (dc_i),
        .busy_o     (busy_o),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .done_o     (done_o),
        .min1_o     (min1_o),
        .min2_o     (min2_o),
        .idx_o      (idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_dc(input int d);
        return (d < 2) ? 2 : ((d > 16) ? 16 : d);
    endfunction

    // min1 = smallest value, idx = its first position, min2 = smallest of the rest.
    function automatic exp_t ref_model(input int n);
        exp_t e;
        logic [31:0] w;
        logic signed [7:0] s;
        int m1, m2, id, v;
        e = '0;
        for (int l = 0; l < SIMD; l++) begin
            m1 = 1000;
            id = 0;
            for (int j = 0; j < n; j++) begin
                w = bq[j]; s = w[l*8 +: 8]; v = int'(s);
                if (v < m1) begin m1 = v; id = j; end
            end
            m2 = 1000;
            for (int j = 0; j < n; j++) begin
                w = bq[j]; s = w[l*8 +: 8]; v = int'(s);
                if (j != id && v < m2) m2 = v;
            end
            e.m1[l*8 +: 8]     = 8'(m1);
            e.m2[l*8 +: 8]     = 8'(m2);
            e.idx[l*IDXW +: IDXW] = 4'(id);
        end
        return e;
    endfunction

    task automatic fill_random(input int n);
        bq.delete();
        repeat (n) bq.push_back($urandom);
    endtask

    // Called at #1 after an edge with the DUT idle; returns in the same phase, idle again.
    task automatic do_search(input int dcv, input int stall_at, input int stall_len, input int glitch_at);
        int   n;
        exp_t e;
        n = clamp_dc(dcv);
        e = ref_model(n);
        sb.push_back(e);
        start_i = 1'b1;
        dc_i    = 5'(dcv);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'd1);
        for (int j = 0; j < n; j++) begin
            if (j == stall_at) begin
                repeat (stall_len) begin
                    in_valid_i = 1'b0;
                    @(posedge clk_i); #1;
                    chk("ready_in_stall", 64'(in_ready_o), 64'd1);
                    chk("done_in_stall", 64'(done_o), 64'd0);
                end
            end
            chk("ready_run", 64'(in_ready_o), 64'd1);
            chk("done_early", 64'(done_o), 64'd0);
            chk("min1_hold", 64'(min1_o), 64'(prev.m1));
            in_valid_i = 1'b1;
            in_data_i  = bq[j];
            if (j == glitch_at) begin
                start_i = 1'b1;
                dc_i    = 5'd2;
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        in_valid_i = 1'b0;
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("busy_in_done", 64'(busy_o), 64'd1);
        chk("ready_in_done", 64'(in_ready_o), 64'd0);
        prev = e;
        @(posedge clk_i); #1;
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("idle_after_done", 64'(busy_o), 64'd0);
    endtask

    // Monitor: every done_o must match the oldest predicted result.
    always @(negedge clk_i) begin
        if (rst_ni && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_min1", 64'(min1_o), 64'(mon_e.m1));
                chk("sb_min2", 64'(min2_o), 64'(mon_e.m2));
                chk("sb_idx", 64'(idx_o), 64'(mon_e.idx));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        dc_i = '0; in_data_i = '0; prev = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_min1", 64'(min1_o), 64'd0);
        chk("rst_min2", 64'(min2_o), 64'd0);
        chk("rst_idx", 64'(idx_o), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Basic search on lane 0
        bq = '{32'h7F7F7F05, 32'h7F7F7FFD, 32'h7F7F7F07, 32'h7F7F7FFF};
        do_search(4, -1, 0, -1);
        chk("basic_min1", 64'(min1_o), 64'h7F7F7FFD);
        chk("basic_min2", 64'(min2_o), 64'h7F7F7FFF);
        chk("basic_idx", 64'(idx_o), 64'h0001);

        // Ties and lane independence
        bq = '{32'h807FF802, 32'h007F0402, 32'h017FF809};
        do_search(3, -1, 0, -1);
        chk("tie_min1", 64'(min1_o), 64'h807FF802);
        chk("tie_min2", 64'(min2_o), 64'h007FF802);
        chk("tie_idx", 64'(idx_o), 64'h0000);

        // dc below 2 clamps up
        fill_random(2);
        do_search(0, -1, 0, -1);

        // dc above DC_MAX clamps down; min1 of lane 0 placed on the last beat
        fill_random(16);
        for (int j = 0; j < 15; j++) begin
            tmp = bq[j]; tmp[7:0] = 8'($urandom_range(0, 127)); bq[j] = tmp;
        end
        tmp = bq[15]; tmp[7:0] = 8'h80; bq[15] = tmp;
        do_search(31, -1, 0, -1);
        tmp = 32'(idx_o);
        chk("max_idx_lane0", 64'(tmp[3:0]), 64'd15);

        // Three-cycle stall mid-stream
        fill_random(6);
        do_search(6, 3, 3, -1);

        // start during RUN (with a different dc) must be ignored
        fill_random(5);
        do_search(5, -1, 0, 2);

        // flush on beat 2 of 4
        start_i = 1'b1; dc_i = 5'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = $urandom;
        @(posedge clk_i); #1;
        in_data_i = 32'h80808080; flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_ready", 64'(in_ready_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        chk("flush_min1_keep", 64'(min1_o), 64'(prev.m1));
        chk("flush_min2_keep", 64'(min2_o), 64'(prev.m2));
        chk("flush_idx_keep", 64'(idx_o), 64'(prev.idx));
        @(posedge clk_i); #1;
        chk("flush_no_done", 64'(done_o), 64'd0);

        // start with flush in IDLE stays idle
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("startflush_busy", 64'(busy_o), 64'd0);
        chk("startflush_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk_i); #1;

        // Async reset mid-RUN, between edges
        start_i = 1'b1; dc_i = 5'd8;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) begin
            in_valid_i = 1'b1; in_data_i = $urandom;
            @(posedge clk_i); #1;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_ready", 64'(in_ready_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_min1", 64'(min1_o), 64'd0);
        chk("arst_min2", 64'(min2_o), 64'd0);
        chk("arst_idx", 64'(idx_o), 64'd0);
        in_valid_i = 1'b0;
        prev = '0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Back-to-back random searches (start in the cycle after each done)
        for (int k = 0; k < 20; k++) begin
            int dcv, n;
            dcv = int'($urandom_range(0, 20));
            n   = clamp_dc(dcv);
            fill_random(n);
            if ($urandom_range(0, 1) == 1)
                do_search(dcv, int'($urandom_range(0, n - 1)), int'($urandom_range(1, 4)), -1);
            else
                do_search(dcv, -1, 0, -1);
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
